// File: rtl/serial_port_if.sv
// Processor-side handshake bundle for one serial_port channel:
// valid/ready towards the transmitter, valid/ack from the receiver.
interface serial_port_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic              rx_overrun;
  logic              rx_frame_err;

  // Processor / bus side
  modport master (
    output tx_data, tx_valid, rx_ack,
    input  tx_ready, rx_data, rx_valid, rx_overrun, rx_frame_err
  );

  // Peripheral side
  modport slave (
    input  tx_data, tx_valid, rx_ack,
    output tx_ready, rx_data, rx_valid, rx_overrun, rx_frame_err
  );
endinterface

// File: rtl/serial_port.sv
// Framed serial port: start bit, DATA_W data bits, stop bit.
// Independent TX and RX engines sharing only the bit-period / bit-order
// configuration inputs, each latched at the start of its own frame.
module serial_port #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_msb_first,
  output logic             Serial_output,
  input  logic             Serial_input,
  serial_port_if.slave     bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Effective bit period minus one (P-1), clamped so that P >= 4.
  logic [DIV_W-1:0] w_div_eff;
  // floor(P/2) = floor((w_div_eff+1)/2), computed without overflow.
  logic [DIV_W-1:0] w_half;

  assign w_div_eff = (cfg_div < DIV_W'(3)) ? DIV_W'(3) : cfg_div;
  assign w_half    = (w_div_eff >> 1) + {{(DIV_W-1){1'b0}}, w_div_eff[0]};

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  state_t            r_tx_state;
  logic              r_tx_line;
  logic              r_tx_ready;
  logic [DIV_W-1:0]  r_tx_cnt;
  logic [DIV_W-1:0]  r_tx_div;
  logic              r_tx_msb;
  logic [DATA_W-1:0] r_tx_shift;
  logic [CNT_W-1:0]  r_tx_bits;

  logic              w_tx_bit;
  logic [DATA_W-1:0] w_tx_next;

  assign w_tx_bit  = r_tx_msb ? r_tx_shift[DATA_W-1] : r_tx_shift[0];
  assign w_tx_next = r_tx_msb ? (r_tx_shift << 1) : (r_tx_shift >> 1);

  // TX frame sequencer; line and ready are registered so they change together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= S_IDLE;
      r_tx_line  <= 1'b1;
      r_tx_ready <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_div   <= '0;
      r_tx_msb   <= 1'b0;
      r_tx_shift <= '0;
      r_tx_bits  <= '0;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (bus.tx_valid) begin
            r_tx_state <= S_START;
            r_tx_line  <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_cnt   <= w_div_eff;
            r_tx_div   <= w_div_eff;
            r_tx_msb   <= cfg_msb_first;
            r_tx_shift <= bus.tx_data;
          end
        end
        S_START: begin
          if (r_tx_cnt == '0) begin
            r_tx_state <= S_DATA;
            r_tx_cnt   <= r_tx_div;
            r_tx_line  <= w_tx_bit;
            r_tx_shift <= w_tx_next;
            r_tx_bits  <= CNT_W'(DATA_W - 1);
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= r_tx_div;
            if (r_tx_bits == '0) begin
              r_tx_state <= S_STOP;
              r_tx_line  <= 1'b1;
            end else begin
              r_tx_line  <= w_tx_bit;
              r_tx_shift <= w_tx_next;
              r_tx_bits  <= r_tx_bits - 1'b1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (r_tx_cnt == '0) begin
            r_tx_state <= S_IDLE;
            r_tx_ready <= 1'b1;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        default: begin
          r_tx_state <= S_IDLE;
          r_tx_line  <= 1'b1;
          r_tx_ready <= 1'b1;
        end
      endcase
    end
  end

  assign Serial_output = r_tx_line;
  assign bus.tx_ready  = r_tx_ready;

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  logic [1:0] r_sync;
  logic       w_rx_in;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    // NOTE: non-blocking assignment keeps each flop one stage behind the other.
    else       r_sync <= {r_sync[0], Serial_input};
  end

  assign w_rx_in = r_sync[1];

  state_t            r_rx_state;
  logic              r_rx_armed;
  logic [DIV_W-1:0]  r_rx_cnt;
  logic [DIV_W-1:0]  r_rx_div;
  logic              r_rx_msb;
  logic [DATA_W-1:0] r_rx_shift;
  logic [CNT_W-1:0]  r_rx_bits;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rx_overrun;
  logic              r_rx_frame_err;

  logic [DATA_W-1:0] w_rx_next;

  assign w_rx_next = r_rx_msb
                   ? ((r_rx_shift << 1) | DATA_W'(w_rx_in))
                   : ((r_rx_shift >> 1) | (DATA_W'(w_rx_in) << (DATA_W - 1)));

  // RX frame sequencer plus the delivery / acknowledge bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state     <= S_IDLE;
      r_rx_armed     <= 1'b1;
      r_rx_cnt       <= '0;
      r_rx_div       <= '0;
      r_rx_msb       <= 1'b0;
      r_rx_shift     <= '0;
      r_rx_bits      <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rx_overrun   <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      // Consumer takes the word; a delivery in this same cycle overrides
      // these clears because its assignments come later in the block.
      if (bus.rx_ack && r_rx_valid) begin
        r_rx_valid     <= 1'b0;
        r_rx_overrun   <= 1'b0;
        r_rx_frame_err <= 1'b0;
      end

      case (r_rx_state)
        S_IDLE: begin
          if (!r_rx_armed) begin
            // After a frame, wait for a high line before looking for a start.
            r_rx_armed <= w_rx_in;
          end else if (!w_rx_in) begin
            r_rx_state <= S_START;
            r_rx_cnt   <= w_half;
            r_rx_div   <= w_div_eff;
            r_rx_msb   <= cfg_msb_first;
          end
        end
        S_START: begin
          if (r_rx_cnt == '0) begin
            if (w_rx_in) begin
              r_rx_state <= S_IDLE;  // glitch, not a start bit
            end else begin
              r_rx_state <= S_DATA;
              r_rx_cnt   <= r_rx_div;
              r_rx_bits  <= CNT_W'(DATA_W - 1);
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_shift <= w_rx_next;
            r_rx_cnt   <= r_rx_div;
            if (r_rx_bits == '0) r_rx_state <= S_STOP;
            else                 r_rx_bits  <= r_rx_bits - 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (r_rx_cnt == '0) begin
            r_rx_state <= S_IDLE;
            r_rx_armed <= w_rx_in;
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !bus.rx_ack) begin
              // Unread word is being overwritten: flags accumulate.
              r_rx_overrun   <= 1'b1;
              r_rx_frame_err <= r_rx_frame_err | ~w_rx_in;
            end else begin
              // Slot empty or freed this cycle: flags describe the new frame only.
              r_rx_overrun   <= 1'b0;
              r_rx_frame_err <= ~w_rx_in;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        default: begin
          r_rx_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data      = r_rx_data;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.rx_overrun   = r_rx_overrun;
  assign bus.rx_frame_err = r_rx_frame_err;

endmodule
